// File: rtl/selector_sched.sv
// Step sequencer for the four-lane nibble selector array. It plays a programmable table of lane configurations, one step per accepted transfer.
// Every output is registered, and the first step appears one cycle after start. A step holds on the outputs until out_ready accepts it.
module selector_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [27:0]   cfg_data,
  input  logic [AW:0]   num_steps,
  input  logic          loop,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          step_valid,
  output logic [AW-1:0] step_idx,
  output logic [11:0]   selA,
  output logic [11:0]   selB,
  output logic [3:0]    sel,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0] MAX_STEPS = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] last_idx;
  logic          loop_q;
  logic [27:0]   tbl [DEPTH];
  logic [AW-1:0] next_idx;
  logic          xfer;

  assign next_idx = step_idx + AW'(1);
  assign xfer     = step_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state      <= IDLE;
      last_idx   <= '0;
      loop_q     <= 1'b0;
      step_valid <= 1'b0;
      step_idx   <= '0;
      selA       <= '0;
      selB       <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // Table writes are only safe while nothing is being played out.
      if (cfg_we) begin
        if (state == IDLE) tbl[cfg_addr] <= cfg_data;
        else               err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (num_steps == '0 || num_steps > MAX_STEPS) begin
              err <= 1'b1;
            end else begin
              last_idx          <= AW'(num_steps - 1'b1);
              loop_q            <= loop;
              {sel, selB, selA} <= tbl[0];
              step_idx          <= '0;
              step_valid        <= 1'b1;
              busy              <= 1'b1;
              state             <= RUN;
            end
          end
        end
        RUN: begin
          if (start) err <= 1'b1;
          // Abort takes priority over a transfer, so the current entry is left on the outputs.
          if (abort) begin
            step_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (xfer) begin
            if (step_idx != last_idx) begin
              step_idx          <= next_idx;
              {sel, selB, selA} <= tbl[next_idx];
            end else if (loop_q) begin
              step_idx          <= '0;
              {sel, selB, selA} <= tbl[0];
            end else begin
              step_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selector_sched.sv
// Bench for selector_sched. It uses a step scoreboard, a table of command vectors, and directed corner sequences.
module tb_selector_sched;

  logic        clk = 1'b0;
  logic        reset_L, cfg_we, loop, start, abort, out_ready;
  logic [2:0]  cfg_addr;
  logic [27:0] cfg_data;
  logic [3:0]  num_steps;
  logic        step_valid, busy, done, err;
  logic [2:0]  step_idx;
  logic [11:0] selA, selB;
  logic [3:0]  sel;

  selector_sched #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset_L(reset_L), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_steps(num_steps), .loop(loop), .start(start),
    .abort(abort), .out_ready(out_ready), .step_valid(step_valid),
    .step_idx(step_idx), .selA(selA), .selB(selB), .sel(sel), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [27:0] ent;
  } exp_t;

  typedef struct {
    logic [3:0] ns;
    logic       exp_err;
    logic       exp_run;
  } vec_t;

  exp_t        q[$];
  logic [27:0] tbl_m [8];
  vec_t        vecs [6];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          cyc, dn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [2:0] a, input logic [27:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic do_start(input logic [3:0] ns, input logic lp);
    num_steps = ns; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_prog(input int n, input int total);
    exp_t e;
    for (int k = 0; k < total; k++) begin
      e.idx = 3'(k % n);
      e.ent = tbl_m[k % n];
      q.push_back(e);
    end
  endtask

  // mode 0: out_ready always high; mode 1: ready pattern 1,0,0,1,0,0,...
  task automatic play(input int n, input int mode, output int cycles, output int dones);
    exp_t e;
    int   got;
    got = 0; cycles = 0; dones = 0;
    while (got < n && cycles < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      @(negedge clk);
      if (done) dones++;
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'(q.size()), 32'd1);
        break;
      end
      e = q[0];
      chk("step_valid", 32'(step_valid), 32'd1);
      chk("step_idx", 32'(step_idx), 32'(e.idx));
      chk("entry", {4'h0, sel, selB, selA}, {4'h0, e.ent});
      if (out_ready) begin
        void'(q.pop_front());
        got++;
      end
      tick();
      cycles++;
    end
    if (got < n) chk("transfers_timeout", 32'(got), 32'(n));
    out_ready = 1'b0;
  endtask

  task automatic chk_done;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("valid_after_done", 32'(step_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0] = '{4'd0,  1'b1, 1'b0};
    vecs[1] = '{4'd9,  1'b1, 1'b0};
    vecs[2] = '{4'd15, 1'b1, 1'b0};
    vecs[3] = '{4'd1,  1'b0, 1'b1};
    vecs[4] = '{4'd8,  1'b0, 1'b1};
    vecs[5] = '{4'd2,  1'b0, 1'b1};

    reset_L = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; num_steps = '0;
    loop = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tbl_m[i] = '0;
    tick(); tick();
    @(negedge clk);
    chk("reset_outs", {step_valid, busy, done, err, step_idx, sel, selB, selA}, 32'd0);
    tick();
    reset_L = 1'b1;

    for (int i = 0; i < 8; i++) prog(3'(i), 28'($urandom));

    // Four steps back to back with ready held high.
    out_ready = 1'b1;
    do_start(4'd4, 1'b0);
    push_prog(4, 4);
    play(4, 0, cyc, dn);
    chk("sustained_cycles", 32'(cyc), 32'd4);
    chk("no_early_done", 32'(dn), 32'd0);
    chk_done();

    // The same program with ready stalls must still deliver each step exactly once.
    do_start(4'd4, 1'b0);
    push_prog(4, 4);
    play(4, 1, cyc, dn);
    chk("stall_cycles", 32'(cyc), 32'd10);
    chk_done();

    // A looping program runs for 10 transfers and is then aborted during a transfer.
    out_ready = 1'b1;
    do_start(4'd3, 1'b1);
    push_prog(3, 10);
    play(10, 0, cyc, dn);
    chk("loop_no_done", 32'(dn), 32'd0);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("pre_abort_idx", 32'(step_idx), 32'd1);
    tick();
    abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("abort_idle", {30'd0, busy, step_valid}, 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_hold_idx", 32'(step_idx), 32'd1);
    chk("abort_hold_entry", {4'h0, sel, selB, selA}, {4'h0, tbl_m[1]});
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_noeffect", {29'd0, busy, err, done}, 32'd0);
    tick();

    // Table of start commands: out-of-range counts are rejected, valid counts play through.
    foreach (vecs[v]) begin
      out_ready = 1'b0;
      do_start(vecs[v].ns, 1'b0);
      @(negedge clk);
      chk("cmd_err", 32'(err), 32'(vecs[v].exp_err));
      chk("cmd_busy", 32'(busy), 32'(vecs[v].exp_run));
      chk("cmd_valid", 32'(step_valid), 32'(vecs[v].exp_run));
      tick();
      if (vecs[v].exp_run) begin
        push_prog(int'(vecs[v].ns), int'(vecs[v].ns));
        play(int'(vecs[v].ns), 0, cyc, dn);
        chk_done();
      end
    end

    // A start during RUN is rejected and does not disturb the running sequence.
    out_ready = 1'b0;
    do_start(4'd4, 1'b0);
    num_steps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("start_in_run_err", 32'(err), 32'd1);
    chk("start_in_run_idx", 32'(step_idx), 32'd0);
    tick();
    push_prog(4, 4);
    play(4, 0, cyc, dn);
    chk_done();

    // A table write during RUN is dropped, and entry 2 keeps its old value.
    do_start(4'd3, 1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = ~tbl_m[2];
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("we_in_run_err", 32'(err), 32'd1);
    tick();
    push_prog(3, 3);
    play(3, 0, cyc, dn);
    chk_done();
    do_start(4'd3, 1'b0);
    push_prog(3, 3);
    play(3, 0, cyc, dn);
    chk_done();

    // A write and a start in the same cycle load the entry as it was before the write.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 28'h5A5A5A5 ^ tbl_m[0];
    do_start(4'd1, 1'b0);
    cfg_we = 1'b0;
    push_prog(1, 1);
    tbl_m[0] = cfg_data;
    play(1, 0, cyc, dn);
    chk_done();
    do_start(4'd1, 1'b0);
    push_prog(1, 1);
    play(1, 0, cyc, dn);
    chk_done();

    // One-step programs can be restarted every two cycles.
    out_ready = 1'b1;
    do_start(4'd1, 1'b0);
    @(negedge clk);
    chk("b2b_first_valid", 32'(step_valid), 32'd1);
    tick();
    num_steps = 4'd1; start = 1'b1;
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("b2b_restart", {29'd0, step_valid, busy, err}, 32'd6);
    chk("b2b_entry", {4'h0, sel, selB, selA}, {4'h0, tbl_m[0]});
    tick();
    out_ready = 1'b0;
    tick();

    // Reset during RUN clears the outputs and the table, and no done is produced.
    do_start(4'd4, 1'b1);
    reset_L = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_reset_outs", {step_valid, busy, done, err, step_idx, sel, selB, selA}, 32'd0);
    tick();
    reset_L = 1'b1;
    for (int i = 0; i < 8; i++) tbl_m[i] = '0;
    do_start(4'd3, 1'b0);
    push_prog(3, 3);
    play(3, 0, cyc, dn);
    chk_done();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
